// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if: control, sample source, result sink and FFT-core links of the frame sequencer.
interface fft_frame_sequencer_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int IDX_W = 5
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic             src_valid;
    logic             src_ready;
    logic [IN_W-1:0]  src_r;
    logic [IN_W-1:0]  src_i;
    logic             res_valid;
    logic [IDX_W-1:0] res_idx;
    logic [OUT_W-1:0] res_r;
    logic [OUT_W-1:0] res_i;
    logic             core_rst;
    logic             core_in_valid;
    logic [IN_W-1:0]  core_din_r;
    logic [IN_W-1:0]  core_din_i;
    logic             core_out_valid;
    logic [OUT_W-1:0] core_dout_r;
    logic [OUT_W-1:0] core_dout_i;

    modport master (
        input  start, abort, src_valid, src_r, src_i, core_out_valid, core_dout_r, core_dout_i,
        output busy, done, err, src_ready, res_valid, res_idx, res_r, res_i,
               core_rst, core_in_valid, core_din_r, core_din_i
    );

    modport slave (
        output start, abort, src_valid, src_r, src_i, core_out_valid, core_dout_r, core_dout_i,
        input  busy, done, err, src_ready, res_valid, res_idx, res_r, res_i,
               core_rst, core_in_valid, core_din_r, core_din_i
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: buffers one frame, clears the FFT core, streams the frame gaplessly
// into it and forwards the indexed results, reporting done or timeout.
module fft_frame_sequencer #(
    parameter int N_POINTS   = 32,
    parameter int IN_W       = 12,
    parameter int OUT_W      = 16,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input logic                  clk,
    input logic                  reset,
    fft_frame_sequencer_if.master bus
);
    localparam int IW = $clog2(N_POINTS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = CLR_CYCLES > 1 ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, CLR, LOAD, STREAM, WAIT, DRAIN, DONE, ERR} state_t;

    state_t              state;
    logic [IW-1:0]       wr_cnt;
    logic [IW-1:0]       rd_cnt;
    logic [TW-1:0]       timer;
    logic [CW-1:0]       clr_cnt;
    logic [2*IN_W-1:0]   mem [N_POINTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.err           <= 1'b0;
            bus.src_ready     <= 1'b0;
            bus.res_valid     <= 1'b0;
            bus.res_idx       <= '0;
            bus.res_r         <= '0;
            bus.res_i         <= '0;
            bus.core_rst      <= 1'b1;
            bus.core_in_valid <= 1'b0;
            bus.core_din_r    <= '0;
            bus.core_din_i    <= '0;
            wr_cnt            <= '0;
            rd_cnt            <= '0;
            timer             <= '0;
            clr_cnt           <= '0;
            for (int k = 0; k < N_POINTS; k++) mem[k] <= '0;
        end else begin
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.res_valid <= 1'b0;
            if (bus.abort) begin
                state             <= IDLE;
                bus.busy          <= 1'b0;
                bus.src_ready     <= 1'b0;
                bus.core_in_valid <= 1'b0;
                bus.core_rst      <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        state    <= CLR;
                        bus.busy <= 1'b1;
                        clr_cnt  <= '0;
                    end
                    CLR: if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
                        state         <= LOAD;
                        bus.core_rst  <= 1'b0;
                        bus.src_ready <= 1'b1;
                        wr_cnt        <= '0;
                    end else clr_cnt <= clr_cnt + 1'b1;
                    LOAD: if (bus.src_valid) begin
                        mem[wr_cnt] <= {bus.src_r, bus.src_i};
                        wr_cnt      <= wr_cnt + 1'b1;
                        // Sample 0 goes out on the next cycle; wr_cnt then tracks the following read slot.
                        if (wr_cnt == IW'(N_POINTS - 1)) begin
                            state                            <= STREAM;
                            bus.src_ready                    <= 1'b0;
                            bus.core_in_valid                <= 1'b1;
                            {bus.core_din_r, bus.core_din_i} <= mem[0];
                            wr_cnt                           <= IW'(1);
                        end
                    end
                    STREAM: if (wr_cnt == '0) begin
                        state             <= WAIT;
                        bus.core_in_valid <= 1'b0;
                        timer             <= '0;
                        rd_cnt            <= '0;
                    end else begin
                        {bus.core_din_r, bus.core_din_i} <= mem[wr_cnt];
                        wr_cnt                           <= wr_cnt + 1'b1;
                    end
                    WAIT, DRAIN: if (bus.core_out_valid) begin
                        bus.res_valid <= 1'b1;
                        bus.res_idx   <= rd_cnt;
                        bus.res_r     <= bus.core_dout_r;
                        bus.res_i     <= bus.core_dout_i;
                        rd_cnt        <= rd_cnt + 1'b1;
                        state         <= DRAIN;
                        if (rd_cnt == IW'(N_POINTS - 1)) begin
                            state        <= DONE;
                            bus.done     <= 1'b1;
                            bus.core_rst <= 1'b1;
                        end
                    end else if (state == WAIT) begin
                        if (timer == TW'(TIMEOUT)) begin
                            state        <= ERR;
                            bus.err      <= 1'b1;
                            bus.core_rst <= 1'b1;
                        end else timer <= timer + 1'b1;
                    end
                    DONE, ERR: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: random frames through the sequencer against a behavioural DFT core
// and a frame-level expectation of ordering, timing and control pulses.
module tb_fft_frame_sequencer;
    localparam int N    = 32;
    localparam int CLR  = 2;
    localparam int TO   = 255;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fft_frame_sequencer_if bus ();
    fft_frame_sequencer #(.N_POINTS(N), .IN_W(12), .OUT_W(16), .CLR_CYCLES(CLR), .TIMEOUT(TO))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int src_r_a [N];
    int src_i_a [N];
    int core_r_a[N];
    int core_i_a[N];

    function automatic int rnd(input real v);
        return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // X[k] = sum x[n] * exp(-j*2*pi*k*n/N), packed {re, im}
    function automatic logic [31:0] dft_bin(input int k, input bit from_core);
        real sr, si, a, xr, xi;
        sr = 0.0;
        si = 0.0;
        for (int n = 0; n < N; n++) begin
            xr = from_core ? core_r_a[n] : src_r_a[n];
            xi = from_core ? core_i_a[n] : src_i_a[n];
            a  = 2.0 * 3.141592653589793 * k * n / N;
            sr += xr * $cos(a) + xi * $sin(a);
            si += xi * $cos(a) - xr * $sin(a);
        end
        return {16'(rnd(sr)), 16'(rnd(si))};
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_in = 0, wait_cnt = 0, out_i = 0, gaps = 0, extra = 0;
    int core_lat = 1, last_in_cyc = 0, fall_cyc = 0, err_cyc = 0, n_done = 0, n_err = 0;
    bit emitting = 0, core_never = 0, core_gappy = 0, in_rst = 1;
    logic [31:0] core_out[N];
    logic [36:0] res_q[$];

    // Core model and result monitor share one process so cycle stamps are consistent.
    always @(negedge clk) begin
        if (bus.res_valid) res_q.push_back({bus.res_idx, bus.res_r, bus.res_i});
        if (bus.done) n_done++;
        if (bus.err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (bus.core_rst) begin
            in_rst             = 1;
            n_in               = 0;
            emitting           = 0;
            bus.core_out_valid = 1'b0;
        end else begin
            if (in_rst) fall_cyc = cyc;
            in_rst = 0;
            if (bus.core_in_valid && n_in < N) begin
                core_r_a[n_in] = $signed(bus.core_din_r);
                core_i_a[n_in] = $signed(bus.core_din_i);
                n_in++;
                if (n_in == N) begin
                    for (int k = 0; k < N; k++) core_out[k] = dft_bin(k, 1);
                    wait_cnt    = core_lat;
                    emitting    = 1;
                    out_i       = 0;
                    last_in_cyc = cyc;
                end
            end else if (bus.core_in_valid) extra++;
            else if (n_in > 0 && n_in < N) gaps++;
            bus.core_out_valid = 1'b0;
            if (emitting) begin
                if (wait_cnt > 0) wait_cnt--;
                else if (!core_never && (!core_gappy || $urandom_range(0, 1) == 1)) begin
                    bus.core_out_valid               = 1'b1;
                    {bus.core_dout_r, bus.core_dout_i} = core_out[out_i];
                    out_i++;
                    if (out_i == N) emitting = 0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int start_cyc = 0;

    task automatic begin_frame(input int pat, input bit gappy, input bit never, input int lat);
        for (int i = 0; i < N; i++) begin
            src_r_a[i] = pat == 1 ? (i == 0 ? 100 : 0) : pat == 2 ? 50 : int'($urandom_range(0, 1000)) - 500;
            src_i_a[i] = pat == 0 ? int'($urandom_range(0, 1000)) - 500 : 0;
        end
        core_gappy = gappy;
        core_never = never;
        core_lat   = lat;
        res_q.delete();
        n_done = 0;
        n_err  = 0;
        gaps   = 0;
        extra  = 0;
        bus.start = 1'b1;
        start_cyc = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    // Returns the number of samples offered into accepted slots.
    task automatic feed(input bit src_gap, input bit extra_start, input int stop_at, output int k);
        int t;
        k = 0;
        t = 0;
        while (k < stop_at && t < 2000) begin
            tick();
            t++;
            bus.src_valid = 1'b0;
            bus.start     = extra_start && k == 5;
            if (bus.src_ready && (!src_gap || t % 2 == 0)) begin
                bus.src_valid = 1'b1;
                bus.src_r     = 12'(src_r_a[k]);
                bus.src_i     = 12'(src_i_a[k]);
                k++;
            end else if (!bus.src_ready) begin
                bus.src_valid = 1'($urandom_range(0, 1));
                bus.src_r     = 12'($urandom);
                bus.src_i     = 12'($urandom);
            end
        end
        tick();
        bus.src_valid = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic do_abort(input string tag);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_core_rst"}, bus.core_rst, 1);
        check({tag, "_src_ready"}, bus.src_ready, 0);
        check({tag, "_core_in_valid"}, bus.core_in_valid, 0);
        n_done = 0;
        n_err  = 0;
        repeat (40) tick();
        check({tag, "_no_done_err"}, n_done + n_err, 0);
    endtask

    task automatic run_frame(input int pat, input bit src_gap, input bit gappy, input bit never,
                             input int lat, input int abort_at, input bit extra_start);
        int k, t;
        begin_frame(pat, gappy, never, lat);
        feed(src_gap, extra_start, abort_at == 1 ? 10 : N, k);
        check("clr_len", fall_cyc - start_cyc, CLR + 1);
        if (abort_at == 1) begin
            do_abort("abort_load");
            return;
        end
        check("load_cnt", k, N);
        t = 0;
        while (n_done == 0 && n_err == 0 && t < 2000) begin
            tick();
            t++;
            if (abort_at == 2 && res_q.size() >= 5) begin
                do_abort("abort_drain");
                return;
            end
        end
        repeat (3) tick();
        check("done_cnt", n_done, never ? 0 : 1);
        check("err_cnt", n_err, never ? 1 : 0);
        check("core_gaps", gaps + extra, 0);
        check("res_cnt", res_q.size(), never ? 0 : N);
        // WAIT is entered one cycle after the last sample; the timer then spans TIMEOUT+1 cycles.
        if (never) check("err_lat", err_cyc - last_in_cyc, TO + 2);
        for (int i = 0; i < res_q.size(); i++) begin
            check("res_idx", res_q[i][36:32], i);
            check("res_data", res_q[i][31:0], dft_bin(i, 0));
        end
        check("idle_busy", bus.busy, 0);
        check("idle_core_rst", bus.core_rst, 1);
    endtask

    initial begin
        int k, t;
        bus.start          = 1'b0;
        bus.abort          = 1'b0;
        bus.src_valid      = 1'b0;
        bus.src_r          = '0;
        bus.src_i          = '0;
        bus.core_out_valid = 1'b0;
        bus.core_dout_r    = '0;
        bus.core_dout_i    = '0;
        repeat (3) tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_src_ready", bus.src_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_core_in_valid", bus.core_in_valid, 0);
        check("rst_core_rst", bus.core_rst, 1);
        reset = 1'b0;
        tick();

        run_frame(1, 0, 0, 0, 3, 0, 0);
        run_frame(1, 1, 0, 0, 5, 0, 0);
        run_frame(2, 0, 0, 0, 2, 0, 0);
        run_frame(1, 0, 0, 0, 4, 0, 0);
        run_frame(0, 0, 0, 1, 1, 0, 0);
        run_frame(0, 0, 0, 0, 3, 1, 0);
        run_frame(0, 0, 0, 0, 3, 0, 0);
        run_frame(0, 0, 1, 0, 6, 2, 0);
        run_frame(0, 1, 1, 0, 2, 0, 0);

        begin_frame(0, 0, 0, 8);
        feed(0, 0, N, k);
        t = 0;
        while (n_in < 10 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("stream_reached", n_in >= 10, 1);
        #1 reset = 1'b1;
        #1;
        check("async_busy", bus.busy, 0);
        check("async_core_rst", bus.core_rst, 1);
        check("async_core_in_valid", bus.core_in_valid, 0);
        check("async_src_ready", bus.src_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        check("abort_beats_start", bus.busy, 0);

        run_frame(0, 0, 0, 0, 2, 0, 1);
        repeat (4) run_frame(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                             int'($urandom_range(1, 20)), 0, 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
